acc_writeback: RTL and testbench

ACC_WRITEBACK -- requirements
Module: acc_writeback

---
 rtl/tpu_pkg.sv | 13 +
 rtl/relu_unit.sv | 10 +
 rtl/acc_writeback.sv | 106 ++++++++++
 tb/tb_acc_writeback.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared widths and writeback FSM state encoding for the accumulator-to-buffer path.
package tpu_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    WR0  = 3'd2,
    WR1  = 3'd3,
    DONE = 3'd4
  } wb_state_t;
endpackage

// File: rtl/relu_unit.sv
// Combinational ReLU: a negative two's-complement input becomes zero when enabled.
module relu_unit #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] din_i,
  input  logic              en_i,
  output logic [DATA_W-1:0] dout_o
);
  assign dout_o = (en_i && din_i[DATA_W-1]) ? '0 : din_i;
endmodule

// File: rtl/acc_writeback.sv
// Captures two accumulator results after full rises and writes them to the unified buffer.
module acc_writeback
  import tpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              full,
  input  logic [DATA_W-1:0] acc_mem_0,
  input  logic [DATA_W-1:0] acc_mem_1,
  input  logic              relu_en,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output wb_state_t         state_dbg
);
  // Write port handshake: a write transfers on a cycle where wr_en and wr_ready are
  // both high; while wr_ready is low, wr_en/wr_addr/wr_data hold their values.

  wb_state_t         state_q, state_d;
  logic              full_q;
  logic              relu_q;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] res0_q, res1_q;
  logic [DATA_W-1:0] relu0, relu1;
  logic              overrun_q;
  logic              rise;

  assign rise      = full & ~full_q;
  assign state_dbg = state_q;

  relu_unit #(.DATA_W(DATA_W)) u_relu0 (.din_i(acc_mem_0), .en_i(relu_q), .dout_o(relu0));
  relu_unit #(.DATA_W(DATA_W)) u_relu1 (.din_i(acc_mem_1), .en_i(relu_q), .dout_o(relu1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise) state_d = ARM;
      ARM:     state_d = WR0;
      WR0:     if (wr_ready) state_d = WR1;
      WR1:     if (wr_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      full_q    <= 1'b0;
      relu_q    <= 1'b0;
      base_q    <= '0;
      res0_q    <= '0;
      res1_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      full_q  <= full;
      if (state_q == IDLE && rise) begin
        relu_q <= relu_en;
        base_q <= base_addr;
      end
      if (state_q == ARM) begin
        res0_q <= relu0;
        res1_q <= relu1;
      end
      // DONE counts as busy, so a rise there is also an overrun.
      if (rise && state_q != IDLE) overrun_q <= 1'b1;
    end
  end

  // Outputs are forced quiet while reset is high so an aborted write never transfers.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    busy    = 1'b0;
    done    = 1'b0;
    overrun = 1'b0;
    if (!reset) begin
      busy    = (state_q != IDLE);
      overrun = overrun_q;
      case (state_q)
        WR0: begin
          wr_en   = 1'b1;
          wr_addr = base_q;
          wr_data = res0_q;
        end
        WR1: begin
          wr_en   = 1'b1;
          wr_addr = base_q + ADDR_W'(1);
          wr_data = res1_q;
        end
        DONE:    done = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_acc_writeback.sv
// Bench for acc_writeback: job-level reference model with per-cycle compare plus directed scenarios.
module tb_acc_writeback;
  import tpu_pkg::*;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset, full, relu_en, wr_ready;
  logic [DW-1:0] acc_mem_0, acc_mem_1;
  logic [AW-1:0] base_addr;
  logic          wr_en, busy, done, overrun;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  wb_state_t     state_dbg;

  always #5 clk = ~clk;

  acc_writeback #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .full(full), .acc_mem_0(acc_mem_0), .acc_mem_1(acc_mem_1),
    .relu_en(relu_en), .base_addr(base_addr), .wr_ready(wr_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .overrun(overrun),
    .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: a job is "arming" for one cycle, then owns a queue of pending
  // writes, then owes one done pulse.
  bit             m_prev_full = 1'b0;
  bit             m_arming    = 1'b0;
  bit             m_done_pend = 1'b0;
  bit             m_overrun   = 1'b0;
  bit             m_relu      = 1'b0;
  logic [AW-1:0]  m_base      = '0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] log_q[$];
  int             done_cnt = 0;
  bit             chk_en   = 1'b0;

  function automatic logic [DW-1:0] relu_ref(input logic [DW-1:0] v, input bit en);
    if (en && $signed(v) < 0) return '0;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial forever begin
    logic [AW-1:0] a1;
    bit rise, busy_m;
    @(posedge clk);
    chk_en = 1'b1;
    if (reset) begin
      exp_q.delete();
      m_arming = 0; m_done_pend = 0; m_overrun = 0; m_prev_full = 0;
    end else begin
      if (wr_en && wr_ready) log_q.push_back({wr_addr, wr_data});
      if (done) done_cnt++;
      rise   = full && !m_prev_full;
      busy_m = m_arming || exp_q.size() != 0 || m_done_pend;
      if (rise && busy_m) m_overrun = 1;
      if (m_done_pend) m_done_pend = 0;
      else if (m_arming) begin
        m_arming = 0;
        a1 = m_base + 8'd1;
        exp_q.push_back({m_base, relu_ref(acc_mem_0, m_relu)});
        exp_q.push_back({a1, relu_ref(acc_mem_1, m_relu)});
      end else if (exp_q.size() != 0) begin
        if (wr_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) m_done_pend = 1;
        end
      end else if (rise) begin
        m_arming = 1; m_relu = relu_en; m_base = base_addr;
      end
      m_prev_full = full;
    end
  end

  initial forever begin
    logic [AW+DW-1:0] front;
    bit exp_en, exp_busy;
    @(negedge clk);
    if (chk_en) begin
      exp_en   = !reset && !m_arming && !m_done_pend && exp_q.size() != 0;
      exp_busy = !reset && (m_arming || exp_q.size() != 0 || m_done_pend);
      front    = exp_en ? exp_q[0] : '0;
      check("cyc_wr_en", wr_en, exp_en);
      check("cyc_wr_addr", wr_addr, front[AW+DW-1:DW]);
      check("cyc_wr_data", wr_data, front[DW-1:0]);
      check("cyc_busy", busy, exp_busy);
      check("cyc_done", done, !reset && m_done_pend);
      check("cyc_overrun", overrun, !reset && m_overrun);
    end
  end

  task automatic clear_log();
    log_q.delete();
    done_cnt = 0;
  endtask

  task automatic run_job(input logic [AW-1:0] b, input logic [DW-1:0] a0,
                         input logic [DW-1:0] a1, input bit r);
    int k;
    base_addr = b; acc_mem_0 = a0; acc_mem_1 = a1; relu_en = r; wr_ready = 1; full = 1;
    k = 0;
    step(1);
    while (!done && k < 30) begin
      step(1);
      k++;
    end
    check("job_done_seen", done, 1'b1);
    full = 0;
    step(1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; full = 0; relu_en = 0; wr_ready = 1;
    acc_mem_0 = '0; acc_mem_1 = '0; base_addr = '0;
    step(2);
    check("reset_wr_en", wr_en, 1'b0);
    check("reset_busy", busy, 1'b0);
    reset = 0;
    step(1);
    check("idle_state", state_dbg, IDLE);
    check("idle_overrun", overrun, 1'b0);

    // Basic job with cycle-by-cycle latency pins
    clear_log();
    base_addr = 8'h10; acc_mem_0 = 32'd5; acc_mem_1 = 32'hFFFF_FFFD; relu_en = 0; full = 1;
    step(1);
    check("lat_arm_wr_en", wr_en, 1'b0);
    check("lat_arm_busy", busy, 1'b1);
    step(1);
    check("lat_wr0_en", wr_en, 1'b1);
    check("lat_wr0_addr", wr_addr, 8'h10);
    check("lat_wr0_data", wr_data, 32'd5);
    step(1);
    check("lat_wr1_addr", wr_addr, 8'h11);
    check("lat_wr1_data", wr_data, 32'hFFFF_FFFD);
    step(1);
    check("lat_done", done, 1'b1);
    check("lat_done_wr_en", wr_en, 1'b0);
    step(1);
    check("lat_idle_busy", busy, 1'b0);
    check("lat_idle_done", done, 1'b0);
    full = 0;
    step(1);
    check("basic_nwr", log_q.size(), 2);
    check("basic_w0", log_q[0], {8'h10, 32'd5});
    check("basic_w1", log_q[1], {8'h11, 32'hFFFF_FFFD});
    check("basic_ndone", done_cnt, 1);

    // ReLU clamps the negative result only
    clear_log();
    run_job(8'h10, 32'd5, 32'hFFFF_FFFD, 1'b1);
    check("relu_nwr", log_q.size(), 2);
    check("relu_w0", log_q[0], {8'h10, 32'd5});
    check("relu_w1", log_q[1], {8'h11, 32'd0});

    // Address wrap
    clear_log();
    run_job(8'hFF, 32'd7, 32'd9, 1'b0);
    check("wrap_nwr", log_q.size(), 2);
    check("wrap_w0", log_q[0], {8'hFF, 32'd7});
    check("wrap_w1", log_q[1], {8'h00, 32'd9});

    // Back-pressure: 3 stall cycles in WR0, 2 in WR1
    clear_log();
    base_addr = 8'h40; acc_mem_0 = 32'd100; acc_mem_1 = 32'd200; relu_en = 0;
    wr_ready = 0; full = 1;
    step(1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("stall0_en", wr_en, 1'b1);
      check("stall0_addr", wr_addr, 8'h40);
      check("stall0_data", wr_data, 32'd100);
    end
    wr_ready = 1;
    step(1);
    wr_ready = 0;
    for (int i = 0; i < 2; i++) begin
      check("stall1_en", wr_en, 1'b1);
      check("stall1_addr", wr_addr, 8'h41);
      check("stall1_data", wr_data, 32'd200);
      step(1);
    end
    wr_ready = 1;
    step(1);
    check("stall_done", done, 1'b1);
    step(1);
    full = 0;
    step(1);
    check("stall_nwr", log_q.size(), 2);
    check("stall_ndone", done_cnt, 1);

    // Re-rise of full during WR1 is an overrun, not a new job
    clear_log();
    base_addr = 8'h50; acc_mem_0 = 32'd1; acc_mem_1 = 32'd2; wr_ready = 1; full = 1;
    step(2);
    step(1);
    wr_ready = 0; full = 0;
    step(1);
    full = 1;
    step(1);
    check("ovr_in_wr1", wr_addr, 8'h51);
    wr_ready = 1;
    step(1);
    check("ovr_done", done, 1'b1);
    step(5);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_no_retrigger", busy, 1'b0);
    check("ovr_nwr", log_q.size(), 2);
    check("ovr_ndone", done_cnt, 1);

    // Reset in WR0 aborts the job and clears overrun
    full = 0;
    step(1);
    clear_log();
    base_addr = 8'h20; acc_mem_0 = 32'd1; acc_mem_1 = 32'd2; wr_ready = 0; full = 1;
    step(2);
    check("abort_in_wr0", wr_en, 1'b1);
    reset = 1; full = 0;
    step(1);
    reset = 0;
    check("abort_wr_en", wr_en, 1'b0);
    check("abort_addr", wr_addr, 8'h00);
    check("abort_data", wr_data, 32'd0);
    check("abort_busy", busy, 1'b0);
    check("abort_overrun", overrun, 1'b0);
    check("abort_state", state_dbg, IDLE);
    step(3);
    check("abort_nwr", log_q.size(), 0);
    check("abort_ndone", done_cnt, 0);
    run_job(8'h30, 32'd11, 32'hFFFF_FFFC, 1'b1);
    check("fresh_nwr", log_q.size(), 2);
    check("fresh_w0", log_q[0], {8'h30, 32'd11});
    check("fresh_w1", log_q[1], {8'h31, 32'd0});

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) full = ~full;
      acc_mem_0 = $urandom;
      acc_mem_1 = $urandom;
      relu_en   = 1'($urandom_range(0, 1));
      base_addr = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      wr_ready  = ($urandom_range(0, 9) < 7);
      reset     = ($urandom_range(0, 99) == 0);
      step(1);
    end
    reset = 0; full = 0; wr_ready = 1;
    step(10);
    check("final_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
